// File: rtl/pc_fetch_redirect.sv
// pc_fetch_redirect
// Fetch stage sitting right after branch resolution. It owns the program
// counter and the IF/ID pipeline register. It steers fetch to the branch
// target on a taken branch, squashes wrong-path instructions, and holds
// while the hazard unit asks for a stall.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   switch_branch  taken branch: redirect fetch to branch_target
//   Flush          squash the IF/ID register
//   branch_target  resolved branch target (low two bits are ignored)
//   stall          hazard-unit hold request
//   instr_in       instruction word read from memory at pc_out
//   pc_out         current fetch address
//   if_id_pc       PC of the instruction held in IF/ID
//   if_id_instr    instruction held in IF/ID (NOP when it is a bubble)
//   if_id_valid    IF/ID holds a real instruction
//   id_ex_flush    registered one-cycle bubble request for ID/EX
//   redirect_count taken redirects since reset, wraps silently
//
// Every output comes straight from a register, so there is no
// combinational path from any input to any output.
module pc_fetch_redirect #(
    parameter int unsigned         PC_W     = 64,
    parameter logic [PC_W-1:0]     RESET_PC = '0,
    parameter int unsigned         CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              switch_branch,
    input  logic              Flush,
    input  logic [PC_W-1:0]   branch_target,
    input  logic              stall,
    input  logic [31:0]       instr_in,
    output logic [PC_W-1:0]   pc_out,
    output logic [PC_W-1:0]   if_id_pc,
    output logic [31:0]       if_id_instr,
    output logic              if_id_valid,
    output logic              id_ex_flush,
    output logic [CNT_W-1:0]  redirect_count
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_e;

    // What this edge does, after applying the fixed priority
    // redirect > squash-only > stall > advance.
    typedef enum logic [1:0] {
        ACT_ADVANCE  = 2'd0,
        ACT_STALL    = 2'd1,
        ACT_SQUASH   = 2'd2,
        ACT_REDIRECT = 2'd3
    } action_e;

    state_e           state_q, state_d;
    action_e          act;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  if_pc_q, if_pc_d;
    logic [31:0]      if_instr_q, if_instr_d;
    logic             if_valid_q, if_valid_d;
    logic             flush_q, flush_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        act = ACT_ADVANCE;
        if (switch_branch)  act = ACT_REDIRECT;
        else if (Flush)     act = ACT_SQUASH;
        else if (stall)     act = ACT_STALL;
    end

    // Next state: the same priority applies in every state, so FLUSH
    // naturally lasts one cycle unless another redirect/squash arrives.
    always_comb begin
        state_d = RUN;
        unique case (state_q)
            RUN, STALL, FLUSH: begin
                unique case (act)
                    ACT_REDIRECT, ACT_SQUASH: state_d = FLUSH;
                    ACT_STALL:                state_d = STALL;
                    default:                  state_d = RUN;
                endcase
            end
            default: state_d = RUN;
        endcase
    end

    // Datapath next-state.
    always_comb begin
        pc_d       = pc_q + PC_W'(4);
        if_pc_d    = pc_q;
        if_instr_d = instr_in;
        if_valid_d = 1'b1;
        flush_d    = 1'b0;
        cnt_d      = cnt_q;
        unique case (act)
            ACT_REDIRECT: begin
                // Targets are word aligned; drop the low bits.
                pc_d       = {branch_target[PC_W-1:2], 2'b00};
                if_pc_d    = '0;
                if_instr_d = NOP;
                if_valid_d = 1'b0;
                flush_d    = 1'b1;
                cnt_d      = cnt_q + CNT_W'(1);
            end
            ACT_SQUASH: begin
                if_pc_d    = '0;
                if_instr_d = NOP;
                if_valid_d = 1'b0;
            end
            ACT_STALL: begin
                pc_d       = pc_q;
                if_pc_d    = if_pc_q;
                if_instr_d = if_instr_q;
                if_valid_d = if_valid_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            if_pc_q    <= '0;
            if_instr_q <= NOP;
            if_valid_q <= 1'b0;
            flush_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            if_valid_q <= if_valid_d;
            flush_q    <= flush_d;
            cnt_q      <= cnt_d;
        end
    end

    assign pc_out         = pc_q;
    assign if_id_pc       = if_pc_q;
    assign if_id_instr    = if_instr_q;
    assign if_id_valid    = if_valid_q;
    assign id_ex_flush    = flush_q;
    assign redirect_count = cnt_q;

endmodule

// File: tb/tb_pc_fetch_redirect.sv
module tb_pc_fetch_redirect;

    localparam int PC_W  = 64;
    localparam int CNT_W = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              reset;
    logic              switch_branch;
    logic              Flush;
    logic [PC_W-1:0]   branch_target;
    logic              stall;
    logic [31:0]       instr_in;
    logic [PC_W-1:0]   pc_out;
    logic [PC_W-1:0]   if_id_pc;
    logic [31:0]       if_id_instr;
    logic              if_id_valid;
    logic              id_ex_flush;
    logic [CNT_W-1:0]  redirect_count;

    int checks = 0;
    int errors = 0;

    pc_fetch_redirect #(.PC_W(PC_W), .RESET_PC('0), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .switch_branch(switch_branch), .Flush(Flush),
        .branch_target(branch_target), .stall(stall), .instr_in(instr_in),
        .pc_out(pc_out), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
        .if_id_valid(if_id_valid), .id_ex_flush(id_ex_flush),
        .redirect_count(redirect_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: applies the per-edge rules directly to an abstract
    // view of the fetch stage (next PC, IF/ID contents, flush, counter).
    logic [63:0] m_pc, m_ifpc;
    logic [31:0] m_instr;
    logic        m_valid, m_flush;
    int unsigned m_cnt;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pc = 0; m_ifpc = 0; m_instr = NOP; m_valid = 0; m_flush = 0; m_cnt = 0;
        end else if (switch_branch) begin
            m_pc = branch_target & ~64'd3;
            m_ifpc = 0; m_instr = NOP; m_valid = 0; m_flush = 1;
            m_cnt = (m_cnt + 1) % 65536;
        end else if (Flush) begin
            m_ifpc = 0; m_instr = NOP; m_valid = 0; m_flush = 0;
            m_pc = m_pc + 64'd4;
        end else if (stall) begin
            m_flush = 0;
        end else begin
            m_ifpc = m_pc; m_instr = instr_in; m_valid = 1; m_flush = 0;
            m_pc = m_pc + 64'd4;
        end
    end

    always @(negedge clk) begin
        check("pc_out", pc_out, m_pc);
        check("if_id_pc", if_id_pc, m_ifpc);
        check("if_id_instr", {32'd0, if_id_instr}, {32'd0, m_instr});
        check("if_id_valid", {63'd0, if_id_valid}, {63'd0, m_valid});
        check("id_ex_flush", {63'd0, id_ex_flush}, {63'd0, m_flush});
        check("redirect_count", {48'd0, redirect_count}, 64'(m_cnt));
    end

    // Advance n rising edges, then settle just after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pc"}, pc_out, 64'd0);
        check({tag, "_ifpc"}, if_id_pc, 64'd0);
        check({tag, "_instr"}, {32'd0, if_id_instr}, {32'd0, NOP});
        check({tag, "_valid"}, {63'd0, if_id_valid}, 64'd0);
        check({tag, "_flush"}, {63'd0, id_ex_flush}, 64'd0);
        check({tag, "_cnt"}, {48'd0, redirect_count}, 64'd0);
    endtask

    initial begin
        reset = 1'b0; switch_branch = 0; Flush = 0; stall = 0;
        branch_target = '0; instr_in = 32'hA;
        step(2);
        check_reset_vals("rst");
        reset = 1'b1;

        // Release, three advancing edges.
        step(3);
        check("boot_pc", pc_out, 64'd12);
        check("boot_ifpc", if_id_pc, 64'd8);
        check("boot_valid", {63'd0, if_id_valid}, 64'd1);
        check("boot_flush", {63'd0, id_ex_flush}, 64'd0);
        check("boot_instr", {32'd0, if_id_instr}, 64'hA);

        // Reach 0x20 then redirect to 0x103 (aligned to 0x100).
        step(5);
        check("pre_br_pc", pc_out, 64'h20);
        switch_branch = 1; branch_target = 64'h103;
        step(1);
        switch_branch = 0;
        check("br_pc", pc_out, 64'h100);
        check("br_valid", {63'd0, if_id_valid}, 64'd0);
        check("br_flush", {63'd0, id_ex_flush}, 64'd1);
        check("br_cnt", {48'd0, redirect_count}, 64'd1);
        step(1);
        check("br_flush_drop", {63'd0, id_ex_flush}, 64'd0);
        check("br_ifpc", if_id_pc, 64'h100);
        check("br_valid2", {63'd0, if_id_valid}, 64'd1);
        check("br_pc2", pc_out, 64'h104);

        // Get to pc 0x40 with a valid instruction in IF/ID, then stall 3.
        switch_branch = 1; branch_target = 64'h38;
        step(1);
        switch_branch = 0;
        step(2);
        check("pre_stall_pc", pc_out, 64'h40);
        stall = 1; instr_in = 32'hBEEF;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("stall_pc", pc_out, 64'h40);
            check("stall_ifpc", if_id_pc, 64'h3C);
            check("stall_instr", {32'd0, if_id_instr}, 64'hA);
            check("stall_valid", {63'd0, if_id_valid}, 64'd1);
        end
        stall = 0;
        step(1);
        check("unstall_pc", pc_out, 64'h44);
        check("unstall_ifpc", if_id_pc, 64'h40);
        check("unstall_instr", {32'd0, if_id_instr}, 64'hBEEF);

        // Stall and redirect together: redirect wins.
        stall = 1; switch_branch = 1; branch_target = 64'h200;
        step(1);
        stall = 0; switch_branch = 0;
        check("sr_pc", pc_out, 64'h200);
        check("sr_valid", {63'd0, if_id_valid}, 64'd0);
        check("sr_instr", {32'd0, if_id_instr}, {32'd0, NOP});
        check("sr_flush", {63'd0, id_ex_flush}, 64'd1);
        check("sr_cnt", {48'd0, redirect_count}, 64'd3);

        // Back-to-back redirects.
        switch_branch = 1; branch_target = 64'h300;
        step(1);
        check("b2b_flush1", {63'd0, id_ex_flush}, 64'd1);
        branch_target = 64'h400;
        step(1);
        switch_branch = 0;
        check("b2b_pc", pc_out, 64'h400);
        check("b2b_cnt", {48'd0, redirect_count}, 64'd5);
        check("b2b_flush2", {63'd0, id_ex_flush}, 64'd1);
        step(1);
        check("b2b_flush_drop", {63'd0, id_ex_flush}, 64'd0);

        // Squash only.
        Flush = 1;
        step(1);
        Flush = 0;
        check("sq_pc", pc_out, 64'h408);
        check("sq_valid", {63'd0, if_id_valid}, 64'd0);
        check("sq_flush", {63'd0, id_ex_flush}, 64'd0);
        check("sq_cnt", {48'd0, redirect_count}, 64'd5);

        // Redirect to the last word, then PC wraps to 0.
        switch_branch = 1; branch_target = '1;
        step(1);
        switch_branch = 0;
        check("wrap_pc0", pc_out, 64'hFFFF_FFFF_FFFF_FFFC);
        step(1);
        check("wrap_pc", pc_out, 64'd0);
        check("wrap_ifpc", if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);

        // Counter wrap: run redirects until all-ones, then one more.
        switch_branch = 1; branch_target = 64'h500;
        step(65535 - 6);
        check("cnt_max", {48'd0, redirect_count}, 64'hFFFF);
        step(1);
        switch_branch = 0;
        check("cnt_wrap", {48'd0, redirect_count}, 64'd0);

        // Asynchronous reset in the middle of a stall.
        step(2);
        stall = 1;
        step(2);
        #2 reset = 1'b0;
        #1 check_reset_vals("mid");
        step(1);
        reset = 1'b1; stall = 0;
        step(2);
        check("post_rst_pc", pc_out, 64'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
